// File: rtl/iir_mc_filter_pkg.sv
// Shared defaults, derived widths and FSM state encoding for the
// time-multiplexed multi-channel IIR filter.
package iir_mc_filter_pkg;

  localparam int INPUT_TAPS       = 3;
  localparam int OUTPUT_TAPS      = 2;
  localparam int DATA_WIDTH       = 16;
  localparam int COEFF_WIDTH      = 16;
  localparam int DATA_FRAC_WIDTH  = 8;
  localparam int COEFF_FRAC_WIDTH = 14;
  localparam int CHANNELS         = 4;

  localparam int CHAN_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_WIDTH     = DATA_WIDTH + COEFF_WIDTH + $clog2(INPUT_TAPS + OUTPUT_TAPS);
  localparam int PROCESS_DELAY = INPUT_TAPS + OUTPUT_TAPS + 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_e;

endpackage

// File: rtl/iir_round_sat.sv
// Round-half-up, arithmetic shift by the coefficient fraction width and
// saturation of the accumulator to a signed output sample.
module iir_round_sat #(
  parameter int ACC_WIDTH  = 35,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 14
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         sat
);

  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (FRAC_WIDTH - 1);
  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] rnd;
  logic signed [ACC_WIDTH-1:0] shr;

  always_comb begin
    rnd = acc + HALF;
    shr = rnd >>> FRAC_WIDTH;
    sat = 1'b0;
    y   = shr[DATA_WIDTH-1:0];
    if (shr > MAXV) begin
      y   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      sat = 1'b1;
    end else if (shr < MINV) begin
      y   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/iir_mc_filter.sv
// Multi-channel direct-form-I IIR filter: one shared MAC walks x taps then
// y taps of the selected channel, then rounds, saturates and hands off.
module iir_mc_filter #(
  parameter int INPUT_TAPS       = iir_mc_filter_pkg::INPUT_TAPS,
  parameter int OUTPUT_TAPS      = iir_mc_filter_pkg::OUTPUT_TAPS,
  parameter int DATA_WIDTH       = iir_mc_filter_pkg::DATA_WIDTH,
  parameter int COEFF_WIDTH      = iir_mc_filter_pkg::COEFF_WIDTH,
  parameter int DATA_FRAC_WIDTH  = iir_mc_filter_pkg::DATA_FRAC_WIDTH,
  parameter int COEFF_FRAC_WIDTH = iir_mc_filter_pkg::COEFF_FRAC_WIDTH,
  parameter int CHANNELS         = iir_mc_filter_pkg::CHANNELS,
  localparam int CHAN_WIDTH      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_i,
  input  logic [DATA_WIDTH-1:0]                                  x_i,
  input  logic [CHAN_WIDTH-1:0]                                  chan_i,
  input  logic                                                   valid_i,
  output logic                                                   ready_and_o,
  input  logic [CHANNELS-1:0][INPUT_TAPS-1:0][COEFF_WIDTH-1:0]   coeff_x_i,
  input  logic [CHANNELS-1:0][OUTPUT_TAPS-1:0][COEFF_WIDTH-1:0]  coeff_y_i,
  input  logic                                                   hist_clr_i,
  input  logic [CHAN_WIDTH-1:0]                                  hist_chan_i,
  output logic [DATA_WIDTH-1:0]                                  y_o,
  output logic [CHAN_WIDTH-1:0]                                  chan_o,
  output logic                                                   sat_o,
  output logic                                                   valid_o,
  input  logic                                                   ready_and_i,
  output logic                                                   err_o
);

  import iir_mc_filter_pkg::*;

  localparam int N         = INPUT_TAPS + OUTPUT_TAPS;
  localparam int CNT_W     = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(N);
  localparam int XH        = (INPUT_TAPS > 1) ? INPUT_TAPS - 1 : 1;

  if (CHANNELS < 1 || OUTPUT_TAPS < 1 || COEFF_FRAC_WIDTH < 1 ||
      DATA_FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_cfg
    $error("iir_mc_filter: unsupported parameter combination");
  end

  state_e state, state_n;

  logic                          started;
  logic                          accept;
  logic                          in_range;
  logic                          clr_range;
  logic [CNT_W-1:0]              cnt;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [DATA_WIDTH-1:0]  x_cur;
  logic [CHAN_WIDTH-1:0]         ch_cur;
  logic signed [DATA_WIDTH-1:0]  xh [CHANNELS][XH];
  logic signed [DATA_WIDTH-1:0]  yh [CHANNELS][OUTPUT_TAPS];
  logic signed [DATA_WIDTH-1:0]  taps_d [N];
  logic signed [COEFF_WIDTH-1:0] taps_c [N];
  logic signed [DATA_WIDTH-1:0]  op_d;
  logic signed [COEFF_WIDTH-1:0] op_c;
  logic signed [DATA_WIDTH+COEFF_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]  y_rs;
  logic                          sat_rs;

  // One extra bit so CHANNELS equal to 2**CHAN_WIDTH does not wrap to zero.
  assign in_range  = {1'b0, chan_i} < (CHAN_WIDTH + 1)'(CHANNELS);
  assign clr_range = {1'b0, hist_chan_i} < (CHAN_WIDTH + 1)'(CHANNELS);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ready_and_o = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        ready_and_o = started && !hist_clr_i;
        accept      = valid_i && ready_and_o;
        if (accept && in_range) state_n = MAC;
      end
      MAC:     if (cnt == CNT_W'(N - 1)) state_n = ROUND;
      ROUND:   state_n = OUT;
      OUT:     if (ready_and_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Tap order: new x, x history, then y history of the captured channel.
  always_comb begin
    taps_d[0] = x_cur;
    taps_c[0] = coeff_x_i[ch_cur][0];
    for (int unsigned k = 1; k < INPUT_TAPS; k++) begin
      taps_d[k] = xh[ch_cur][k-1];
      taps_c[k] = coeff_x_i[ch_cur][k];
    end
    for (int unsigned k = 0; k < OUTPUT_TAPS; k++) begin
      taps_d[INPUT_TAPS+k] = yh[ch_cur][k];
      taps_c[INPUT_TAPS+k] = coeff_y_i[ch_cur][k];
    end
    op_d = taps_d[cnt];
    op_c = taps_c[cnt];
    prod = op_d * op_c;
  end

  iir_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (COEFF_FRAC_WIDTH)
  ) u_round_sat (
    .acc (acc),
    .y   (y_rs),
    .sat (sat_rs)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      started <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      x_cur   <= '0;
      ch_cur  <= '0;
      y_o     <= '0;
      chan_o  <= '0;
      sat_o   <= 1'b0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned k = 0; k < XH; k++)          xh[c][k] <= '0;
        for (int unsigned k = 0; k < OUTPUT_TAPS; k++) yh[c][k] <= '0;
      end
    end else begin
      started <= 1'b1;
      err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (hist_clr_i) begin
            if (clr_range) begin
              for (int unsigned k = 0; k < XH; k++)          xh[hist_chan_i][k] <= '0;
              for (int unsigned k = 0; k < OUTPUT_TAPS; k++) yh[hist_chan_i][k] <= '0;
            end
          end else if (accept) begin
            x_cur  <= x_i;
            ch_cur <= chan_i;
            acc    <= '0;
            cnt    <= '0;
            err_o  <= !in_range;
          end
        end
        MAC: begin
          acc <= acc + ACC_WIDTH'(prod);
          cnt <= (cnt == CNT_W'(N - 1)) ? '0 : cnt + 1'b1;
        end
        ROUND: begin
          y_o     <= y_rs;
          chan_o  <= ch_cur;
          sat_o   <= sat_rs;
          valid_o <= 1'b1;
          for (int unsigned k = XH - 1; k > 0; k--) xh[ch_cur][k] <= xh[ch_cur][k-1];
          xh[ch_cur][0] <= x_cur;
          for (int unsigned k = OUTPUT_TAPS - 1; k > 0; k--) yh[ch_cur][k] <= yh[ch_cur][k-1];
          yh[ch_cur][0] <= y_rs;
        end
        OUT: if (ready_and_i) valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mc_filter.sv
// Directed bench for iir_mc_filter: table of per-channel samples with
// hand-computed outputs, plus backpressure, error and reset sequences.
module tb_iir_mc_filter;
  import iir_mc_filter_pkg::*;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]             x_i = '0;
  logic [1:0]              chan_i = '0;
  logic                    valid_i = 1'b0;
  logic                    ready_and_o;
  logic [3:0][2:0][15:0]   coeff_x = '0;
  logic [3:0][1:0][15:0]   coeff_y = '0;
  logic                    hist_clr_i = 1'b0;
  logic [1:0]              hist_chan_i = '0;
  logic [15:0]             y_o;
  logic [1:0]              chan_o;
  logic                    sat_o;
  logic                    valid_o;
  logic                    ready_and_i = 1'b1;
  logic                    err_o;

  logic [15:0]             x3 = '0;
  logic [1:0]              chan3 = '0;
  logic                    valid3 = 1'b0;
  logic                    ready3_o;
  logic [2:0][2:0][15:0]   cx3 = '0;
  logic [2:0][1:0][15:0]   cy3 = '0;
  logic                    clr3 = 1'b0;
  logic [1:0]              clrch3 = '0;
  logic [15:0]             y3;
  logic [1:0]              ch3o;
  logic                    sat3;
  logic                    valid3_o;
  logic                    rdy3_i = 1'b1;
  logic                    err3;

  iir_mc_filter u_dut (
    .clk_i(clk), .reset_i(reset_i), .x_i(x_i), .chan_i(chan_i), .valid_i(valid_i),
    .ready_and_o(ready_and_o), .coeff_x_i(coeff_x), .coeff_y_i(coeff_y),
    .hist_clr_i(hist_clr_i), .hist_chan_i(hist_chan_i), .y_o(y_o), .chan_o(chan_o),
    .sat_o(sat_o), .valid_o(valid_o), .ready_and_i(ready_and_i), .err_o(err_o)
  );

  iir_mc_filter #(.CHANNELS(3)) u_dut3 (
    .clk_i(clk), .reset_i(reset_i), .x_i(x3), .chan_i(chan3), .valid_i(valid3),
    .ready_and_o(ready3_o), .coeff_x_i(cx3), .coeff_y_i(cy3),
    .hist_clr_i(clr3), .hist_chan_i(clrch3), .y_o(y3), .chan_o(ch3o),
    .sat_o(sat3), .valid_o(valid3_o), .ready_and_i(rdy3_i), .err_o(err3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit clr;
    int ch;
    int x;
    int ey;
    int es;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_hist(input int ch);
    @(negedge clk);
    hist_clr_i  = 1'b1;
    hist_chan_i = 2'(ch);
    #1 chk("clr_blocks_ready", int'(ready_and_o), 0);
    @(posedge clk);
    #1 hist_clr_i = 1'b0;
  endtask

  task automatic run_sample(input string name, input int ch, input int x, input int ey, input int es);
    bit seen;
    int lat;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_and_o) begin seen = 1; break; end
    end
    chk({name, " ready"}, int'(seen), 1);
    if (!seen) return;
    chan_i  = 2'(ch);
    x_i     = 16'(x);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin lat = i; break; end
    end
    chk({name, " latency"}, lat, PROCESS_DELAY);
    chk({name, " y"}, int'($signed(y_o)), ey);
    chk({name, " chan"}, int'(chan_o), ch);
    chk({name, " sat"}, int'(sat_o), es);
    @(posedge clk);
    #1 chk({name, " valid_drop"}, int'(valid_o), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int hi_cnt;
    int err_cnt;
    logic [15:0] y_hold;

    coeff_x[0][0] = 16'd16384;
    coeff_x[1][0] = 16'd16384;
    coeff_y[1][0] = 16'd8192;
    coeff_x[2][0] = 16'd16384;
    coeff_x[2][1] = 16'd16384;
    coeff_x[2][2] = 16'd16384;
    coeff_x[3][0] = 16'd8192;

    tbl[0]  = '{0, 0, 256,   256,   0};
    tbl[1]  = '{0, 1, 256,   256,   0};
    tbl[2]  = '{0, 0, 0,     0,     0};
    tbl[3]  = '{0, 1, 0,     128,   0};
    tbl[4]  = '{0, 0, 512,   512,   0};
    tbl[5]  = '{0, 1, 0,     64,    0};
    tbl[6]  = '{0, 3, 257,   129,   0};
    tbl[7]  = '{0, 2, 28672, 28672, 0};
    tbl[8]  = '{0, 2, 28672, 32767, 1};
    tbl[9]  = '{0, 2, 28672, 32767, 1};
    tbl[10] = '{1, 1, 512,   512,   0};
    tbl[11] = '{0, 0, 256,   256,   0};
    tbl[12] = '{0, 1, 0,     256,   0};
    tbl[13] = '{0, 0, 256,   256,   0};
    tbl[14] = '{0, 1, 0,     128,   0};
    tbl[15] = '{1, 1, 512,   512,   0};

    #12;
    chk("rst y_o", int'(y_o), 0);
    chk("rst chan_o", int'(chan_o), 0);
    chk("rst sat_o", int'(sat_o), 0);
    chk("rst valid_o", int'(valid_o), 0);
    chk("rst err_o", int'(err_o), 0);
    chk("rst ready", int'(ready_and_o), 0);
    @(negedge clk);
    reset_i = 1'b1;
    #1 chk("ready before first edge", int'(ready_and_o), 0);
    @(posedge clk);
    #1 chk("ready after first edge", int'(ready_and_o), 1);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].clr) clear_hist(tbl[i].ch);
      run_sample($sformatf("vec%0d", i), tbl[i].ch, tbl[i].x, tbl[i].ey, tbl[i].es);
    end

    // Backpressure: ch0 x=768 held in OUT while a second sample is offered.
    ready_and_i = 1'b0;
    run_sample_hold: begin
      @(negedge clk);
      chan_i = 2'd0; x_i = 16'd768; valid_i = 1'b1;
      @(posedge clk);
      #1 valid_i = 1'b0;
      hi_cnt = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (valid_o) begin hi_cnt = 1; break; end
      end
      chk("bp valid seen", hi_cnt, 1);
      y_hold = y_o;
      chk("bp y", int'(y_hold), 768);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chan_i = 2'd0; x_i = 16'd100; valid_i = 1'b1;
        #1;
        chk("bp valid_o", int'(valid_o), 1);
        chk("bp y_o stable", int'(y_o), int'(y_hold));
        chk("bp chan_o", int'(chan_o), 0);
        chk("bp ready_and_o", int'(ready_and_o), 0);
      end
      @(negedge clk);
      valid_i = 1'b0;
      ready_and_i = 1'b1;
      @(posedge clk);
      #1 chk("bp release", int'(valid_o), 0);
      hi_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk);
        #1 if (valid_o) hi_cnt++;
      end
      chk("bp no extra sample", hi_cnt, 0);
    end

    // Out-of-range channel on the three-channel instance.
    @(negedge clk);
    chk("dut3 ready", int'(ready3_o), 1);
    chan3 = 2'd3; x3 = 16'd256; valid3 = 1'b1;
    @(posedge clk);
    #1 valid3 = 1'b0;
    chk("err pulse", int'(err3), 1);
    err_cnt = 0;
    hi_cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (err3) err_cnt++;
      if (valid3_o) hi_cnt++;
    end
    chk("err single pulse", err_cnt, 0);
    chk("err no valid", hi_cnt, 0);

    // Reset during MAC on ch2 (whose history is non-zero): sample dropped, history zeroed.
    @(negedge clk);
    chan_i = 2'd2; x_i = 16'd256; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_i = 1'b0;
    #1;
    chk("mid rst valid_o", int'(valid_o), 0);
    chk("mid rst y_o", int'(y_o), 0);
    chk("mid rst ready", int'(ready_and_o), 0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (valid_o) hi_cnt++;
    end
    chk("mid rst no output", hi_cnt, 0);
    run_sample("post_rst_impulse", 2, 256, 256, 0);

    pulse_reset();
    run_sample("neg0", 2, -28672, -28672, 0);
    run_sample("neg1", 2, -28672, -32768, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iir_mc_filter.md
Name: iir_mc_filter

Overview:
- Multi-channel, time-multiplexed direct-form-I IIR filter. A single shared multiply-accumulate serves up to CHANNELS independent channels.
- Each channel has its own x/y history and its own coefficient bank.
- Valid/ready streaming interface on input and output; sits in the same datapath slot as the single-channel IIR core.
- Adds over the single-channel core: channel tagging, round-half-up, saturation flag, per-channel history clear, out-of-range channel error.

Parameters:
- INPUT_TAPS, 3, feed-forward taps per channel.
- OUTPUT_TAPS, 2, feedback taps per channel.
- DATA_WIDTH, 16, signed sample width.
- COEFF_WIDTH, 16, signed coefficient width.
- DATA_FRAC_WIDTH, 8, fractional bits of x/y.
- COEFF_FRAC_WIDTH, 14, fractional bits of coefficients.
- CHANNELS, 4, number of channels (>=1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- x_i  in  DATA_WIDTH  signed input sample.
- chan_i  in  CHAN_WIDTH=max(1,$clog2(CHANNELS))  channel of x_i.
- valid_i  in  1  input valid.
- ready_and_o  out  1  input ready.
- coeff_x_i  in  [CHANNELS][INPUT_TAPS] x COEFF_WIDTH  feed-forward coefficients.
- coeff_y_i  in  [CHANNELS][OUTPUT_TAPS] x COEFF_WIDTH  feedback coefficients.
- hist_clr_i  in  1  request to zero the history of channel hist_chan_i.
- hist_chan_i  in  CHAN_WIDTH  channel to clear.
- y_o  out  DATA_WIDTH  signed output sample.
- chan_o  out  CHAN_WIDTH  channel of y_o.
- sat_o  out  1  y_o was saturated (qualified by valid_o).
- valid_o  out  1  output valid.
- ready_and_i  in  1  downstream ready.
- err_o  out  1  one-cycle pulse: sample accepted with chan_i >= CHANNELS.

Behaviour:
- Reset (reset_i=0, asynchronous): state IDLE; all x/y histories zero. Outputs reset to y_o=0, chan_o=0, sat_o=0, valid_o=0, err_o=0, ready_and_o=0. ready_and_o rises the first cycle after reset_i deasserts.
- Reset mid-operation aborts any in-flight sample; it is neither output nor written to history.
- Equation, per channel c: y[n] = sum(k=0..IT-1) bx[c][k]*x[n-k] + sum(k=1..OT) cy[c][k-1]*y[n-k]. Coefficients carry their own sign.
- Accumulator width: ACC_WIDTH = DATA_WIDTH+COEFF_WIDTH+$clog2(IT+OT). Products are full precision.
- Round/saturate: add 2^(COEFF_FRAC_WIDTH-1), arithmetic shift right by COEFF_FRAC_WIDTH, then saturate to signed DATA_WIDTH. sat_o=1 when clipping occurs.
- FSM states: IDLE, MAC, ROUND, OUT.
- IDLE:
  - ready_and_o = !hist_clr_i.
  - If hist_clr_i=1: zero the histories of hist_chan_i (ignored if out of range); no sample is accepted that cycle.
  - Otherwise, on valid_i&&ready_and_o: capture x_i and chan_i.
    - Out-of-range channel: pulse err_o the next cycle, stay IDLE.
    - Valid channel: clear accumulator, go to MAC.
- MAC: one tap per cycle for N=IT+OT cycles; x taps first (the new x_i, then history), then y taps. Counter wraps to ROUND. ready_and_o=0.
- ROUND:
  - Register y_o, chan_o, sat_o; set valid_o=1.
  - Shift the channel's x history in with the new x and its y history in with the saturated y.
  - Go to OUT.
- OUT: hold y_o/chan_o/sat_o/valid_o stable until ready_and_i=1. On that edge valid_o=0 and return to IDLE.
- hist_clr_i outside IDLE is ignored; it must be held until idle.
- Latency: valid_o is visible after edge N+1 counted from the accepting edge. PROCESS_DELAY = IT+OT+1 (6 at defaults). No overlap: minimum throughput is one sample per N+3 cycles with ready_and_i tied high.
- coeff_* are read live during MAC and must be changed only while IDLE; changing them otherwise gives undefined y_o (no hazard to the FSM).
- Other channels' histories are never touched by a sample on channel c.

Decomposition:
- config_pkg gains CHANNELS, CHAN_WIDTH, ACC_WIDTH, PROCESS_DELAY and a state_e enum {IDLE, MAC, ROUND, OUT}.
- Sub-module iir_round_sat: combinational round-half-up, shift and saturate, producing y and sat.
- History storage is register arrays indexed by channel; no RAM.
- The existing interface gains chan_i/chan_o/hist_clr_i/hist_chan_i/sat_o/err_o and per-channel coefficient arrays.

Test Plan:
- Impulse, ch0, bx={16384,0,0}, cy={0,0}, x=0x0100 -> y_o=0x0100, chan_o=0, sat_o=0, valid_o exactly 6 cycles after the accepting edge.
- Recursion plus rounding, ch1, bx={16384,0,0}, cy={8192,0}:
  - x=256,0,0 -> y=256,128,64.
  - Separately, bx={8192,0,0}, x=0x0101 -> y=0x0081 (128.5 rounds up).
- Isolation: interleave ch0 x=0x0100 and ch1 x=0x0200 with ch1 feedback 0.5 -> ch1 outputs 512,256,128 regardless of ch0 traffic; hist_clr_i on ch1 mid-stream -> next ch1 output = b0*x only.
- Saturation, bx={16384,16384,16384}:
  - x=0x7000 x3 -> 0x7000, 0x7FFF(sat_o=1), 0x7FFF(sat_o=1).
  - After reset, x=0x9000 x2 -> 0x9000, 0x8000(sat_o=1).
- Backpressure and errors:
  - Hold ready_and_i=0 for 10 cycles in OUT -> y_o/chan_o/valid_o stable, ready_and_o=0, no new sample accepted.
  - With CHANNELS=3, chan_i=3 -> err_o pulses once, no valid_o.
- Reset mid-MAC: assert reset_i in cycle 3 of MAC -> valid_o stays 0; following impulse on the same channel sees zero history.
